// File: rtl/mxu_pkg.sv
// Shared MXU definitions: weight-loader state encoding and the PE load-path defaults.
package mxu_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } wl_state_e;

   localparam int MXU_PE_LOAD_LAT = 3;
   localparam int MXU_WEIGHT_W    = 8;
   localparam int MXU_IDX_W       = 8;
endpackage

// File: rtl/mxu_weight_loader_if.sv
// Weight stream into the column-top loader: valid/ready with one weight per beat.
interface mxu_weight_loader_if #(parameter int WEIGHT_W = mxu_pkg::MXU_WEIGHT_W);
   logic                w_valid;
   logic [WEIGHT_W-1:0] w_data;
   logic                w_ready;

   modport master (output w_valid, w_data, input w_ready);
   modport slave  (input w_valid, w_data, output w_ready);
endinterface

// File: rtl/mxu_wload_timer.sv
// Loadable down-counter that times the DRAIN phase; flags the last count and expiry.
module mxu_wload_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             last_o,
   output logic             expire_o
);
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        cnt_q <= '0;
      else if (load_i)                cnt_q <= load_val_i;
      else if (en_i && cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
   end

   assign last_o   = (cnt_q == CNT_W'(1));
   assign expire_o = (cnt_q == '0);
endmodule

// File: rtl/mxu_weight_loader.sv
// Column-top weight preload sequencer: streams ROWS tagged weights into PE y=0, then waits for them to settle.
// Define MXU_WLOAD_CHECKSUM_EN to add a 16-bit running checksum of accepted weights.
module mxu_weight_loader
   import mxu_pkg::*;
#(
   parameter int ROWS     = 8,
   parameter int WEIGHT_W = MXU_WEIGHT_W,
   parameter int IDX_W    = MXU_IDX_W,
   parameter int PE_LAT   = MXU_PE_LOAD_LAT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   mxu_weight_loader_if.slave  w,
   output logic                load_phase,
   output logic [IDX_W-1:0]    load_weight_target_y,
   output logic [WEIGHT_W-1:0] load_weight,
   output logic                busy,
   output logic                done
`ifdef MXU_WLOAD_CHECKSUM_EN
   ,
   output logic [15:0]         checksum
`endif
);
   localparam int               DRAIN_N  = ROWS * PE_LAT;
   localparam int               CNT_W    = $clog2(DRAIN_N + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

   wl_state_e           state_q;
   logic [IDX_W-1:0]    idx_q;
   logic                phase_q;
   logic [IDX_W-1:0]    tgt_q;
   logic [WEIGHT_W-1:0] wt_q;
   logic                done_q;
   logic                xfer, last_beat, drain_last, drain_exp;

   // abort wins over a same-cycle transfer, so the beat is simply not taken
   assign w.w_ready = (state_q == LOAD);
   assign xfer      = w.w_valid && w.w_ready && !abort;
   assign last_beat = xfer && (idx_q == LAST_IDX);

   mxu_wload_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (last_beat),
      .load_val_i (CNT_W'(DRAIN_N)),
      .en_i       (state_q == DRAIN),
      .last_o     (drain_last),
      .expire_o   (drain_exp)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         phase_q <= 1'b0;
         tgt_q   <= '0;
         wt_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         phase_q <= 1'b0;
         tgt_q   <= '0;
         wt_q    <= '0;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               state_q <= LOAD;
               idx_q   <= '0;
            end
            LOAD: begin
               if (abort) state_q <= IDLE;
               else if (xfer) begin
                  phase_q <= 1'b1;
                  tgt_q   <= idx_q;
                  wt_q    <= w.w_data;
                  if (idx_q == LAST_IDX) state_q <= DRAIN;
                  else                   idx_q   <= idx_q + 1'b1;
               end
            end
            // done is raised one cycle early so it is visible on the expiry cycle
            DRAIN: begin
               if (abort || drain_exp) state_q <= IDLE;
               else if (drain_last)    done_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef MXU_WLOAD_CHECKSUM_EN
   logic [15:0] csum_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                           csum_q <= '0;
      else if (state_q == IDLE && start) csum_q <= '0;
      else if (xfer)                     csum_q <= csum_q + 16'(w.w_data);
   end

   assign checksum = csum_q;
`endif

   assign load_phase           = phase_q;
   assign load_weight_target_y = tgt_q;
   assign load_weight          = wt_q;
   assign done                 = done_q;
   assign busy                 = (state_q != IDLE);
endmodule

// File: tb/tb_mxu_weight_loader.sv
// Scoreboard bench for mxu_weight_loader (ROWS=4): stimulus queues expected beats/done, a negedge monitor checks them.
module tb_mxu_weight_loader;
   localparam int ROWS = 4;
   localparam int WW   = 8;
   localparam int IW   = 8;
   localparam int LAT  = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          load_phase;
   logic [IW-1:0] tgt;
   logic [WW-1:0] wt;
   logic          busy, done;
`ifdef MXU_WLOAD_CHECKSUM_EN
   logic [15:0]   checksum;
`endif

   mxu_weight_loader_if #(.WEIGHT_W(WW)) wif ();

   mxu_weight_loader #(.ROWS(ROWS), .WEIGHT_W(WW), .IDX_W(IW), .PE_LAT(LAT)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .start                (start),
      .abort                (abort),
      .w                    (wif.slave),
      .load_phase           (load_phase),
      .load_weight_target_y (tgt),
      .load_weight          (wt),
      .busy                 (busy),
      .done                 (done)
`ifdef MXU_WLOAD_CHECKSUM_EN
      ,
      .checksum             (checksum)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {logic [IW-1:0] tgt; logic [WW-1:0] wt;} beat_t;
   typedef struct {int cyc; logic [15:0] csum;} done_t;

   beat_t       beat_q[$];
   done_t       done_q[$];
   beat_t       b;
   done_t       d;
   int          checks = 0;
   int          errors = 0;
   int          last_done_cyc = -100;
   int          s0 = 0;
   int          last_acc = 0;
   logic [15:0] csum = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every load beat must match the head of the scoreboard; idle cycles carry zeros.
   always @(negedge clk) begin
      if (!rst) begin
         if (load_phase) begin
            if (beat_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_beat: target %0d weight %0h with none expected", tgt, wt);
            end else begin
               b = beat_q.pop_front();
               chk("beat_target", tgt, b.tgt);
               chk("beat_weight", wt, b.wt);
            end
         end else begin
            chk("bubble_target", tgt, 0);
            chk("bubble_weight", wt, 0);
         end
         if (done) begin
            if (done_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: done at cycle %0d with none expected", cyc);
            end else begin
               d = done_q.pop_front();
               chk("done_cycle", cyc, d.cyc);
               chk("busy_on_done", busy, 1);
`ifdef MXU_WLOAD_CHECKSUM_EN
               chk("done_checksum", checksum, d.csum);
`endif
            end
            last_done_cyc <= cyc;
         end
         if (cyc == last_done_cyc + 1) chk("busy_after_done", busy, 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      s0    = cyc;
      csum  = '0;
   endtask

   task automatic send_beats(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                             input logic [WW-1:0] w2, input logic [WW-1:0] w3,
                             input int bub_after, input int n_bub,
                             input int abort_beat, input int restart_beat);
      logic [WW-1:0] wts[4];
      int   i, bub, guard;
      logic acc, ab;
      wts = '{w0, w1, w2, w3};
      i = 0; bub = 0; guard = 0;
      while (i < ROWS && guard < 40) begin
         guard++;
         if (i == bub_after + 1 && bub < n_bub) begin
            wif.w_valid = 1'b0; wif.w_data = '0; bub++;
         end else begin
            wif.w_valid = 1'b1; wif.w_data = wts[i];
         end
         ab    = (i == abort_beat) && wif.w_valid;
         abort = ab;
         start = (i == restart_beat);
         acc   = wif.w_valid && wif.w_ready;
         tick();
         abort = 1'b0;
         start = 1'b0;
         if (acc && ab) begin
            wif.w_valid = 1'b0;
            return;
         end
         if (acc) begin
            beat_q.push_back('{IW'(i), wts[i]});
            csum     = csum + 16'(wts[i]);
            last_acc = cyc;
            i++;
         end
      end
      wif.w_valid = 1'b0;
      if (i < ROWS) begin
         checks++; errors++;
         $display("FAIL beats_timeout: accepted %0d beats, required %0d", i, ROWS);
      end else begin
         done_q.push_back('{last_acc + 12, csum});
      end
   endtask

   task automatic wait_done(input int exp_lat, input string name);
      int g = 0;
      while (done_q.size() != 0 && g < 60) begin
         tick(); g++;
      end
      if (done_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL %s_timeout: done never seen, required at cycle %0d", name, done_q[0].cyc);
         done_q.delete();
      end
      tick(); tick();
      chk(name, last_done_cyc - s0, exp_lat);
      chk("busy_idle_after_done", busy, 0);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      wif.w_valid = 1'b0;
      wif.w_data  = '0;
      @(negedge clk); @(negedge clk);
      chk("rst_load_phase", load_phase, 0);
      chk("rst_target", tgt, 0);
      chk("rst_weight", wt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_w_ready", wif.w_ready, 0);
      tick();
      rst = 1'b0;
      idle(2);

      // back-to-back stream: last beat at s0+4, done 12 later
      do_start();
      chk("t1_busy", busy, 1);
      chk("t1_w_ready", wif.w_ready, 1);
      send_beats(8'h11, 8'h22, 8'h33, 8'h44, -1, 0, -1, -1);
      wait_done(16, "t1_done_latency");

      // two bubbles after beat 1 delay done by 2
      do_start();
      send_beats(8'h11, 8'h22, 8'h33, 8'h44, 1, 2, -1, -1);
      wait_done(18, "t2_done_latency");

      // abort coincides with beat 2
      do_start();
      send_beats(8'h11, 8'h22, 8'h33, 8'h44, -1, 0, 2, -1);
      chk("t3_busy", busy, 0);
      chk("t3_w_ready", wif.w_ready, 0);
      idle(20);
      chk("t3_beats_left", beat_q.size(), 0);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("t3_abort_idle", busy, 0);

      // reset in DRAIN, then a fresh sequence
      do_start();
      send_beats(8'h5A, 8'hA5, 8'h01, 8'h80, -1, 0, -1, -1);
      idle(5);
      rst = 1'b1;
      #1;
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_done", done, 0);
      chk("t4_rst_phase", load_phase, 0);
      chk("t4_rst_w_ready", wif.w_ready, 0);
      done_q.delete();
      tick();
      rst = 1'b0;
      idle(20);
      do_start();
      send_beats(8'h5A, 8'hA5, 8'h01, 8'h80, -1, 0, -1, -1);
      wait_done(16, "t4_done_latency");

      // start while busy, in LOAD and in DRAIN
      do_start();
      send_beats(8'h10, 8'h20, 8'h30, 8'h40, -1, 0, -1, 2);
      idle(3);
      start = 1'b1; tick(); start = 1'b0;
      wait_done(16, "t5_done_latency");
      idle(20);
      chk("t5_beats_left", beat_q.size(), 0);

`ifdef MXU_WLOAD_CHECKSUM_EN
      do_start();
      send_beats(8'hFF, 8'hFF, 8'hFF, 8'hFF, -1, 0, -1, -1);
      wait_done(16, "t6_done_latency");
      chk("t6_checksum_hold", checksum, 16'h03FC);
      do_start();
      chk("t6_checksum_clear", checksum, 16'h0000);
      abort = 1'b1; tick(); abort = 1'b0;
      idle(2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
